cc_miss_request_unit: RTL and testbench

Upstream neighbour of the cache data-fill stage. It accepts cache-miss requests from the tag-compare stage, pushes each miss address into the miss-address FIFO, and issues one AXI read burst per miss on the AR channel. Bursts are 8 beats × 8 B, WRAP type, critical word first. It tracks in-flight bursts by counting R-channel last beats, and limits them to a configurable maximum.

---
 rtl/cc_miss_request_unit_pkg.sv | 21 ++
 rtl/cc_outstanding_cnt.sv | 44 ++++
 rtl/cc_miss_request_unit.sv | 116 +++++++++++
 tb/tb_cc_miss_request_unit.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cc_miss_request_unit_pkg.sv
// Package cc_pkg: shared constants and types for the cache-miss request path.
//   - AXI burst-type encodings
//   - Cache-line burst shape: 8 beats x 8 B, WRAP, critical word first
//   - Miss-request FSM state type
package cc_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam int         LINE_BEATS    = 8;
    localparam logic [3:0] ARLEN_LINE    = 4'd7;   // LINE_BEATS - 1
    localparam logic [2:0] ARSIZE_8B     = 3'd3;   // 2^3 = 8 bytes per beat
    localparam int         BEAT_OFFSET_W = 3;      // byte offset within one beat

    typedef enum logic {
        IDLE,
        REQ
    } state_e;

endpackage

// File: rtl/cc_outstanding_cnt.sv
// cc_outstanding_cnt: saturating up/down counter of AXI read bursts in flight.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   inc        : one burst issued (AR handshake)
//   dec        : one burst completed (rlast handshake)
//   count      : bursts currently in flight
//   at_max     : count has reached MAX_OUTSTANDING
// inc and dec together leave the count unchanged. A dec at zero saturates
// at zero and trips a simulation assertion, since it means an rlast arrived
// for a burst that was never issued.
module cc_outstanding_cnt #(
    parameter int  MAX_OUTSTANDING = 4,
    localparam int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             at_max
);

    assign at_max = (count >= CNT_W'(MAX_OUTSTANDING));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else begin
            case ({inc, dec})
                2'b10:   if (!at_max)       count <= count + 1'b1;
                2'b01:   if (count != '0)   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always @(posedge clk) begin
        if (rst_n && dec && !inc) begin
            assert (count != '0)
                else $error("cc_outstanding_cnt: completion with no burst outstanding");
        end
    end

endmodule

// File: rtl/cc_miss_request_unit.sv
// cc_miss_request_unit: turns cache-miss requests into AXI read bursts.
// Each accepted miss is pushed (full byte address) into the miss-address FIFO
// in the accept cycle, and one 8-beat x 8 B WRAP burst is requested on AR the
// cycle after, starting at the 8-byte-aligned critical word. Bursts in flight
// are counted by rlast handshakes and capped at MAX_OUTSTANDING.
// Ports:
//   clk, rst_n                  : clock, asynchronous active-low reset
//   miss_req_valid_i/_addr_i    : miss request from tag compare
//   miss_req_ready_o            : request accepted when valid & ready
//   miss_addr_fifo_full_i       : FIFO back-pressure
//   miss_addr_fifo_wren_o/wdata : FIFO push
//   mem_ar*                     : AXI AR channel (arlen/arsize/arburst constant)
//   mem_rvalid_i/rready_i/rlast_i : R channel, observed for burst completion
//   miss_cnt_o, ar_stall_cnt_o  : perf counters, only with CC_MISS_PERF_CNT_EN
// Build option: define CC_MISS_PERF_CNT_EN to add the two perf counters.
module cc_miss_request_unit
    import cc_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4,
    parameter int ADDR_W          = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              miss_req_valid_i,
    input  logic [ADDR_W-1:0] miss_req_addr_i,
    output logic              miss_req_ready_o,
    input  logic              miss_addr_fifo_full_i,
    output logic              miss_addr_fifo_wren_o,
    output logic [ADDR_W-1:0] miss_addr_fifo_wdata_o,
    output logic              mem_arvalid_o,
    input  logic              mem_arready_i,
    output logic [ADDR_W-1:0] mem_araddr_o,
    output logic [3:0]        mem_arlen_o,
    output logic [2:0]        mem_arsize_o,
    output logic [1:0]        mem_arburst_o,
    input  logic              mem_rvalid_i,
    input  logic              mem_rready_i,
    input  logic              mem_rlast_i
`ifdef CC_MISS_PERF_CNT_EN
    ,
    output logic [31:0]       miss_cnt_o,
    output logic [31:0]       ar_stall_cnt_o
`endif
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    state_e            state;
    logic [ADDR_W-1:0] req_addr;
    logic [CNT_W-1:0]  outstanding;
    logic              at_max;
    logic              accept;
    logic              ar_hs;
    logic              r_done;

    // rst_n gates ready so nothing is accepted while the block is held in reset.
    assign miss_req_ready_o = rst_n && (state == IDLE) && !miss_addr_fifo_full_i && !at_max;
    assign accept           = miss_req_valid_i && miss_req_ready_o;
    assign ar_hs            = (state == REQ) && mem_arready_i;
    assign r_done           = mem_rvalid_i && mem_rready_i && mem_rlast_i;

    assign miss_addr_fifo_wren_o  = accept;
    assign miss_addr_fifo_wdata_o = miss_req_addr_i;

    assign mem_arvalid_o = (state == REQ);
    assign mem_araddr_o  = req_addr;
    assign mem_arlen_o   = ARLEN_LINE;
    assign mem_arsize_o  = ARSIZE_8B;
    assign mem_arburst_o = BURST_WRAP;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            req_addr <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        // Critical word first: start the wrap at the requested beat.
                        req_addr <= {miss_req_addr_i[ADDR_W-1:BEAT_OFFSET_W],
                                     {BEAT_OFFSET_W{1'b0}}};
                        state    <= REQ;
                    end
                end
                REQ: begin
                    if (mem_arready_i) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    cc_outstanding_cnt #(
        .MAX_OUTSTANDING(MAX_OUTSTANDING)
    ) u_outstanding_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (ar_hs),
        .dec   (r_done),
        .count (outstanding),
        .at_max(at_max)
    );

`ifdef CC_MISS_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            miss_cnt_o     <= '0;
            ar_stall_cnt_o <= '0;
        end else begin
            if (accept)                          miss_cnt_o     <= miss_cnt_o + 32'd1;
            if (mem_arvalid_o && !mem_arready_i) ar_stall_cnt_o <= ar_stall_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cc_miss_request_unit.sv
module tb_cc_miss_request_unit;

    localparam int MAXO = 4;
    localparam int AW   = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          miss_req_valid_i;
    logic [AW-1:0] miss_req_addr_i;
    logic          miss_req_ready_o;
    logic          miss_addr_fifo_full_i;
    logic          miss_addr_fifo_wren_o;
    logic [AW-1:0] miss_addr_fifo_wdata_o;
    logic          mem_arvalid_o;
    logic          mem_arready_i;
    logic [AW-1:0] mem_araddr_o;
    logic [3:0]    mem_arlen_o;
    logic [2:0]    mem_arsize_o;
    logic [1:0]    mem_arburst_o;
    logic          mem_rvalid_i;
    logic          mem_rready_i;
    logic          mem_rlast_i;
`ifdef CC_MISS_PERF_CNT_EN
    logic [31:0]   miss_cnt_o;
    logic [31:0]   ar_stall_cnt_o;
`endif

    always #5 clk = ~clk;

    cc_miss_request_unit #(
        .MAX_OUTSTANDING(MAXO),
        .ADDR_W         (AW)
    ) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .miss_req_valid_i      (miss_req_valid_i),
        .miss_req_addr_i       (miss_req_addr_i),
        .miss_req_ready_o      (miss_req_ready_o),
        .miss_addr_fifo_full_i (miss_addr_fifo_full_i),
        .miss_addr_fifo_wren_o (miss_addr_fifo_wren_o),
        .miss_addr_fifo_wdata_o(miss_addr_fifo_wdata_o),
        .mem_arvalid_o         (mem_arvalid_o),
        .mem_arready_i         (mem_arready_i),
        .mem_araddr_o          (mem_araddr_o),
        .mem_arlen_o           (mem_arlen_o),
        .mem_arsize_o          (mem_arsize_o),
        .mem_arburst_o         (mem_arburst_o),
        .mem_rvalid_i          (mem_rvalid_i),
        .mem_rready_i          (mem_rready_i),
        .mem_rlast_i           (mem_rlast_i)
`ifdef CC_MISS_PERF_CNT_EN
        ,
        .miss_cnt_o            (miss_cnt_o),
        .ar_stall_cnt_o        (ar_stall_cnt_o)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    // Behavioural model: one pending AR request at most, an in-flight burst
    // tally, and (optionally) the two perf tallies.
    bit            m_pend, n_pend;
    logic [AW-1:0] m_addr, n_addr;
    int            m_outs, n_outs;
    int unsigned   m_miss, n_miss, m_stall, n_stall;

    always @(negedge clk) begin
        bit exp_ready, acc, hs, cmp;
        chk("arlen",   64'(mem_arlen_o),   64'd7);
        chk("arsize",  64'(mem_arsize_o),  64'd3);
        chk("arburst", 64'(mem_arburst_o), 64'd2);
        if (!rst_n) begin
            chk("rst_ready",   64'(miss_req_ready_o),      64'd0);
            chk("rst_wren",    64'(miss_addr_fifo_wren_o), 64'd0);
            chk("rst_arvalid", 64'(mem_arvalid_o),         64'd0);
            chk("rst_araddr",  64'(mem_araddr_o),          64'd0);
        end else begin
            exp_ready = !m_pend && !miss_addr_fifo_full_i && (m_outs < MAXO);
            acc       = miss_req_valid_i && exp_ready;
            hs        = m_pend && mem_arready_i;
            cmp       = mem_rvalid_i && mem_rready_i && mem_rlast_i;
            chk("m_ready",   64'(miss_req_ready_o),      64'(exp_ready));
            chk("m_wren",    64'(miss_addr_fifo_wren_o), 64'(acc));
            if (acc) chk("m_wdata", 64'(miss_addr_fifo_wdata_o), 64'(miss_req_addr_i));
            chk("m_arvalid", 64'(mem_arvalid_o), 64'(m_pend));
            if (m_pend) chk("m_araddr", 64'(mem_araddr_o), 64'(m_addr));
`ifdef CC_MISS_PERF_CNT_EN
            chk("m_miss_cnt",  64'(miss_cnt_o),     64'(m_miss));
            chk("m_stall_cnt", 64'(ar_stall_cnt_o), 64'(m_stall));
`endif
            n_outs = m_outs + int'(hs) - int'(cmp);
            if (n_outs < 0) n_outs = 0;
            n_pend  = acc ? 1'b1 : (hs ? 1'b0 : m_pend);
            n_addr  = acc ? (miss_req_addr_i & ~AW'(7)) : m_addr;
            n_miss  = m_miss + (acc ? 1 : 0);
            n_stall = m_stall + ((m_pend && !mem_arready_i) ? 1 : 0);
        end
    end

    always @(posedge clk) begin
        if (!rst_n) begin
            m_pend = 0; m_addr = '0; m_outs = 0; m_miss = 0; m_stall = 0;
        end else begin
            m_pend = n_pend; m_addr = n_addr; m_outs = n_outs;
            m_miss = n_miss; m_stall = n_stall;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        miss_req_valid_i = 1'b0; miss_req_addr_i = '0; miss_addr_fifo_full_i = 1'b0;
        mem_arready_i = 1'b0; mem_rvalid_i = 1'b0; mem_rready_i = 1'b0; mem_rlast_i = 1'b0;
        m_pend = 0; m_addr = '0; m_outs = 0; m_miss = 0; m_stall = 0;
        n_pend = 0; n_addr = '0; n_outs = 0; n_miss = 0; n_stall = 0;
        @(negedge clk);
        chk("reset_ready", 64'(miss_req_ready_o), 64'd0);
        tick(); tick();
        rst_n = 1'b1;

        // Single miss, arready tied high
        mem_arready_i = 1'b1;
        miss_req_valid_i = 1'b1; miss_req_addr_i = 32'h0000_1238;
        @(negedge clk);
        chk("t1_wren",  64'(miss_addr_fifo_wren_o),  64'd1);
        chk("t1_wdata", 64'(miss_addr_fifo_wdata_o), 64'h1238);
        tick();
        miss_req_valid_i = 1'b0; miss_req_addr_i = '0;
        @(negedge clk);
        chk("t1_arvalid", 64'(mem_arvalid_o), 64'd1);
        chk("t1_araddr",  64'(mem_araddr_o),  64'h1238);
        chk("t1_arlen",   64'(mem_arlen_o),   64'd7);
        tick();
        @(negedge clk);
        chk("t1_idle_arvalid", 64'(mem_arvalid_o),       64'd0);
        chk("t1_outs",         64'(dut.outstanding),     64'd1);
        chk("t1_ready",        64'(miss_req_ready_o),    64'd1);
        tick();

        // arready low for 3 cycles: request held stable, address aligned
        mem_arready_i = 1'b0;
        miss_req_valid_i = 1'b1; miss_req_addr_i = 32'h0000_2235;
        @(negedge clk);
        chk("t2_wdata", 64'(miss_addr_fifo_wdata_o), 64'h2235);
        tick();
        miss_req_valid_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) mem_arready_i = 1'b1;
            @(negedge clk);
            chk("t2_arvalid", 64'(mem_arvalid_o),    64'd1);
            chk("t2_araddr",  64'(mem_araddr_o),     64'h2230);
            chk("t2_ready",   64'(miss_req_ready_o), 64'd0);
            tick();
        end
        @(negedge clk);
        chk("t2_outs", 64'(dut.outstanding), 64'd2);
        tick();

        // AR handshake and rlast in the same cycle at outstanding 2
        miss_req_valid_i = 1'b1; miss_req_addr_i = 32'h0000_3000;
        tick();
        miss_req_valid_i = 1'b0;
        mem_rvalid_i = 1'b1; mem_rready_i = 1'b1; mem_rlast_i = 1'b1;
        tick();
        mem_rvalid_i = 1'b0; mem_rready_i = 1'b0; mem_rlast_i = 1'b0;
        @(negedge clk);
        chk("t3_outs",       64'(dut.outstanding), 64'd2);
        chk("t3_model_outs", 64'(m_outs),          64'd2);
        tick();

        // Back-to-back misses up to the limit
        miss_req_valid_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            miss_req_addr_i = 32'h0000_4000 + 32'(i * 64);
            tick();
        end
        @(negedge clk);
        chk("t4_ready_full", 64'(miss_req_ready_o),      64'd0);
        chk("t4_wren_full",  64'(miss_addr_fifo_wren_o), 64'd0);
        chk("t4_outs",       64'(dut.outstanding),       64'd4);
        tick();
        mem_rvalid_i = 1'b1; mem_rready_i = 1'b1; mem_rlast_i = 1'b1;
        @(negedge clk);
        chk("t4_ready_same", 64'(miss_req_ready_o), 64'd0);
        tick();
        mem_rvalid_i = 1'b0; mem_rready_i = 1'b0; mem_rlast_i = 1'b0;
        miss_req_addr_i = 32'h0000_5008;
        @(negedge clk);
        chk("t4_ready_after", 64'(miss_req_ready_o),       64'd1);
        chk("t4_wren5",       64'(miss_addr_fifo_wren_o),  64'd1);
        chk("t4_wdata5",      64'(miss_addr_fifo_wdata_o), 64'h5008);
        tick();
        miss_req_valid_i = 1'b0;
        @(negedge clk);
        chk("t4_araddr5", 64'(mem_araddr_o), 64'h5008);
        tick();
        @(negedge clk);
        chk("t4_outs5", 64'(dut.outstanding), 64'd4);
        tick();
        mem_rvalid_i = 1'b1; mem_rready_i = 1'b1; mem_rlast_i = 1'b0;
        tick();
        mem_rlast_i = 1'b1;
        repeat (4) tick();
        mem_rvalid_i = 1'b0; mem_rready_i = 1'b0; mem_rlast_i = 1'b0;
        @(negedge clk);
        chk("t4_drained",       64'(dut.outstanding), 64'd0);
        chk("t4_model_drained", 64'(m_outs),          64'd0);
        tick();

        // FIFO full blocks the accept; releasing full accepts that cycle
        miss_addr_fifo_full_i = 1'b1;
        miss_req_valid_i = 1'b1; miss_req_addr_i = 32'h0000_6010;
        @(negedge clk);
        chk("t5_ready", 64'(miss_req_ready_o),      64'd0);
        chk("t5_wren",  64'(miss_addr_fifo_wren_o), 64'd0);
        tick();
        @(negedge clk);
        chk("t5_arvalid", 64'(mem_arvalid_o), 64'd0);
        tick();
        miss_addr_fifo_full_i = 1'b0;
        @(negedge clk);
        chk("t5_wren_go",  64'(miss_addr_fifo_wren_o),  64'd1);
        chk("t5_wdata_go", 64'(miss_addr_fifo_wdata_o), 64'h6010);
        tick();
        miss_req_valid_i = 1'b0;
        @(negedge clk);
        chk("t5_araddr", 64'(mem_araddr_o), 64'h6010);
        tick();
        @(negedge clk);
        chk("t5_outs", 64'(dut.outstanding), 64'd1);
        tick();

        // Reset asserted while a request is pending
        mem_arready_i = 1'b0;
        miss_req_valid_i = 1'b1; miss_req_addr_i = 32'h0000_7018;
        tick();
        miss_req_valid_i = 1'b0;
        chk("t6_arvalid_pre", 64'(mem_arvalid_o), 64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t6_arvalid_rst", 64'(mem_arvalid_o),    64'd0);
        chk("t6_ready_rst",   64'(miss_req_ready_o), 64'd0);
        tick(); tick();
        rst_n = 1'b1; mem_arready_i = 1'b1;
        @(negedge clk);
        chk("t6_outs",    64'(dut.outstanding),  64'd0);
        chk("t6_ready",   64'(miss_req_ready_o), 64'd1);
        chk("t6_arvalid", 64'(mem_arvalid_o),    64'd0);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
